// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32x32 storage, two combinational read ports, write counter.
// Define WB_REGFILE_BYPASS_EN to forward a same-cycle write (ResultW) onto the read ports.
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic        MemtoRegW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ALUOutW,
    input  logic [4:0]  WriteRegW,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] ResultW,
    output logic [31:0] WbCount
);

    logic [31:0] regs_q [32];
    logic [31:0] wb_count_q;
    logic        commit;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
    // Writes to register 0 are dropped and never counted.
    assign commit  = RegWriteW && (WriteRegW != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (commit) begin
            regs_q[WriteRegW] <= ResultW;
            wb_count_q        <= wb_count_q + 32'd1;
        end
    end

    assign WbCount = wb_count_q;

`ifdef WB_REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    // Gated by rst_n so reads stay zero while reset is held.
    assign hit1 = rst_n && commit && (A1 == WriteRegW);
    assign hit2 = rst_n && commit && (A2 == WriteRegW);

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != 5'd0) RD1 = hit1 ? ResultW : regs_q[A1];
        if (A2 != 5'd0) RD2 = hit2 ? ResultW : regs_q[A2];
    end
`else
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != 5'd0) RD1 = regs_q[A1];
        if (A2 != 5'd0) RD2 = regs_q[A2];
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs, negedge monitor compares.
// Honours WB_REGFILE_BYPASS_EN in its reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] WbCount;

    wb_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .WbCount   (WbCount)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] res;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl[32];
    logic [31:0] mcnt;
    int          checks = 0;
    int          passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got 0x%08h, required 0x%08h", tag, fld, act, exp);
    endtask

    // Monitor: compares whatever the driver has queued against the live outputs.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.tag, "RD1", RD1, e.rd1);
            chk(e.tag, "RD2", RD2, e.rd2);
            chk(e.tag, "ResultW", ResultW, e.res);
            chk(e.tag, "WbCount", WbCount, e.cnt);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic r, input logic we,
                                           input logic [4:0] wr, input logic [31:0] res);
        if (!r || a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
        if (we && wr != 5'd0 && a == wr) return res;
`endif
        return mdl[a];
    endfunction

    // Inputs change 1ns after the rising edge; reset changes here are mid-cycle.
    task automatic cycle(input string tag, input logic r, input logic we, input logic m2r,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2);
        exp_t        e;
        logic [31:0] res;
        @(posedge clk);
        #1;
        rst_n     = r;
        RegWriteW = we;
        MemtoRegW = m2r;
        ReadDataW = rdata;
        ALUOutW   = alu;
        WriteRegW = wr;
        A1        = a1;
        A2        = a2;
        if (!r) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            mcnt = 32'd0;
        end
        res   = m2r ? rdata : alu;
        e.tag = tag;
        e.rd1 = exp_rd(a1, r, we, wr, res);
        e.rd2 = exp_rd(a2, r, we, wr, res);
        e.res = res;
        e.cnt = mcnt;
        sb_q.push_back(e);
        if (r && we && wr != 5'd0) begin
            mdl[wr] = res;
            mcnt    = mcnt + 32'd1;
        end
    endtask

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b0; MemtoRegW = 1'b0; ReadDataW = '0; ALUOutW = '0;
        WriteRegW = '0; A1 = '0; A2 = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mcnt = 32'd0;

        cycle("reset",     0, 1, 0, 32'h0, 32'h5555_0000, 5'd4, 5'd4, 5'd0);
        cycle("wr5",       1, 1, 0, 32'h0, 32'h1234_5678, 5'd5, 5'd0, 5'd0);
        cycle("rd5",       1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        cycle("sel31",     1, 1, 1, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 5'd31, 5'd5, 5'd31);
        cycle("rd31",      1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31);
        cycle("r0w",       1, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        cycle("r0r",       1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
        cycle("w7a",       1, 1, 0, 32'h0, 32'h1, 5'd7, 5'd0, 5'd0);
        cycle("rdw7",      1, 1, 0, 32'h0, 32'h2, 5'd7, 5'd7, 5'd7);
        cycle("rdw7post",  1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        cycle("w3",        1, 1, 0, 32'h0, 32'h0000_0033, 5'd3, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++)
            cycle("weoff", 1, 0, 0, 32'h0, 32'h0000_AAAA, 5'd3, 5'd3, 5'd0);
        cycle("weoffpost", 1, 0, 0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd7);
        cycle("midrst",    0, 1, 1, 32'hCAFE_F00D, 32'h0, 5'd9, 5'd5, 5'd31);
        cycle("rsthold",   0, 1, 0, 32'h0, 32'h7777_7777, 5'd9, 5'd9, 5'd7);
        cycle("rstrel",    1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            logic [4:0] a1;
            logic [4:0] a2;
            wr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) wr = 5'd0;
            a1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle("rand", ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, wr, a1, a2);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
